// File: rtl/gate_response_checker.sv
//==============================================================================
// Module   : gate_response_checker
// Purpose  : Checks sampled {a,b,c} of a two-input gate against a truth table,
//            tracks vector coverage, counts mismatches and reports a verdict.
//            Optional first-mismatch capture: define GATE_CHK_FIRST_ERR_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_response_checker #(
    parameter logic [3:0] TRUTH_TABLE = 4'b1000,
    parameter int         ERR_W       = 8,
    parameter int         TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_vld,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       cov
`ifdef GATE_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_vld,
    output logic [2:0]       first_err_vec
`endif
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CYC_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1_vld;
    logic [2:0]         r_s1_vec;
    logic [CNT_W-1:0]   r_cyc;
    logic [3:0]         r_cov;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_err_pulse;
    logic               r_timeout;
    logic               r_pass;

    logic               w_in_run;
    logic               w_launch;
    logic               w_cmp_vld;
    logic               w_mismatch;
    logic [3:0]         w_cov_nxt;
    logic               w_full;
    logic               w_tmo;
    logic               w_end;
    logic [ERR_W-1:0]   w_cnt_nxt;

    assign w_in_run   = (r_state == S_RUN);
    assign w_launch   = start && !w_in_run;
    assign w_cmp_vld  = w_in_run && r_s1_vld;
    assign w_mismatch = w_cmp_vld && (r_s1_vec[0] != TRUTH_TABLE[r_s1_vec[2:1]]);
    assign w_cov_nxt  = r_cov | (w_cmp_vld ? (4'b0001 << r_s1_vec[2:1]) : 4'b0000);
    assign w_full     = (w_cov_nxt == 4'hF);
    // Coverage completing on the same edge as the limit takes precedence.
    assign w_tmo      = (r_cyc == C_CYC_LAST) && !w_full;
    assign w_end      = w_in_run && (w_full || w_tmo);
    assign w_cnt_nxt  = (w_mismatch && (r_err_cnt != C_ERR_MAX)) ?
                        r_err_cnt + ERR_W'(1) : r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_full || w_tmo) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_s1_vld    <= 1'b0;
            r_s1_vec    <= 3'b000;
            r_cyc       <= '0;
            r_cov       <= 4'h0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err_pulse <= w_mismatch;
            if (w_launch) begin
                r_s1_vld  <= 1'b0;
                r_cyc     <= '0;
                r_cov     <= 4'h0;
                r_err_cnt <= '0;
                r_timeout <= 1'b0;
                r_pass    <= 1'b0;
            end else if (w_in_run) begin
                r_cov     <= w_cov_nxt;
                r_err_cnt <= w_cnt_nxt;
                r_cyc     <= r_cyc + CNT_W'(1);
                // A sample arriving on the closing edge is dropped, never compared.
                r_s1_vld  <= smp_vld && !w_end;
                if (smp_vld) begin
                    r_s1_vec <= {a, b, c};
                end
                if (w_end) begin
                    r_timeout <= !w_full;
                    r_pass    <= w_full && (w_cnt_nxt == '0);
                end
            end
        end
    end

`ifdef GATE_CHK_FIRST_ERR_EN
    logic       r_first_vld;
    logic [2:0] r_first_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_vld <= 1'b0;
            r_first_vec <= 3'b000;
        end else if (w_launch) begin
            r_first_vld <= 1'b0;
            r_first_vec <= 3'b000;
        end else if (w_mismatch && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_vec <= r_s1_vec;
        end
    end

    assign first_err_vld = r_first_vld;
    assign first_err_vec = r_first_vec;
`endif

    assign busy      = w_in_run;
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign cov       = r_cov;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
//==============================================================================
// Module   : tb_gate_response_checker
// Purpose  : Directed, table-driven self-checking bench for gate_response_checker.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst, start, smp_vld, a, b, c;

    logic       busy, done, pass, timeout, err_pulse;
    logic [1:0] err_cnt;
    logic [3:0] cov;
    logic       b_busy, b_done, b_pass, b_timeout, b_err_pulse;
    logic [7:0] b_err_cnt;
    logic [3:0] b_cov;
`ifdef GATE_CHK_FIRST_ERR_EN
    logic       fev, b_fev;
    logic [2:0] fvec, b_fvec;
`endif

    always #5 clk = ~clk;

    // AND checker, small counter and short limit.
    gate_response_checker #(.TRUTH_TABLE(4'b1000), .ERR_W(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .smp_vld(smp_vld),
        .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .cov(cov)
`ifdef GATE_CHK_FIRST_ERR_EN
        , .first_err_vld(fev), .first_err_vec(fvec)
`endif
    );

    // Asymmetric table (c = a & ~b) with default sizing, same stimulus.
    gate_response_checker #(.TRUTH_TABLE(4'b0100)) dut_b (
        .clk(clk), .rst(rst), .start(start), .smp_vld(smp_vld),
        .a(a), .b(b), .c(c),
        .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
        .err_pulse(b_err_pulse), .err_cnt(b_err_cnt), .cov(b_cov)
`ifdef GATE_CHK_FIRST_ERR_EN
        , .first_err_vld(b_fev), .first_err_vec(b_fvec)
`endif
    );

    typedef struct {
        logic       st, v, a, b, c;
        logic       busy, done, pass, to, ep;
        logic [1:0] cnt;
        logic [3:0] cov;
        logic [7:0] cntb;
        logic       fv;
        logic [2:0] fvec;
    } row_t;

    row_t rows[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic st, v, ia, ib, ic, ebusy, edone, epass, eto, eep,
                       input logic [1:0] ecnt, input logic [3:0] ecov,
                       input logic [7:0] ecntb, input logic efv, input logic [2:0] efvec);
        row_t r;
        r.st = st; r.v = v; r.a = ia; r.b = ib; r.c = ic;
        r.busy = ebusy; r.done = edone; r.pass = epass; r.to = eto; r.ep = eep;
        r.cnt = ecnt; r.cov = ecov; r.cntb = ecntb; r.fv = efv; r.fvec = efvec;
        rows.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, v, ia, ib, ic);
        start = st; smp_vld = v; a = ia; b = ib; c = ic;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " pass"}, pass, 1'b0);
        chk({tag, " timeout"}, timeout, 1'b0);
        chk({tag, " err_pulse"}, err_pulse, 1'b0);
        chk({tag, " err_cnt"}, err_cnt, 2'd0);
        chk({tag, " cov"}, cov, 4'h0);
`ifdef GATE_CHK_FIRST_ERR_EN
        chk({tag, " first_err_vld"}, fev, 1'b0);
        chk({tag, " first_err_vec"}, fvec, 3'b000);
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        //   st v a b c | busy done pass to ep cnt cov  cntb fv fvec
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0); // smp in IDLE ignored
        add(1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0); // smp with start ignored
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        add(0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 4'h1, 0, 0, 3'd0);
        add(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 4'h3, 0, 0, 3'd0);
        add(0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 4'h7, 1, 0, 3'd0);
        add(0, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0, 4'hF, 2, 0, 3'd0); // bad smp on closing edge
        add(0, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0, 4'hF, 2, 0, 3'd0); // smp in DONE ignored
        // failing run: last vector 110
        add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        add(0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 4'h1, 0, 0, 3'd0);
        add(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 4'h3, 0, 0, 3'd0);
        add(0, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 4'h7, 1, 0, 3'd0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 4'hF, 1, 1, 3'b110);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 4'hF, 1, 1, 3'b110);
        // restart from DONE, then saturation: five 001 then the rest correct
        add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 1, 1, 4'h1, 1, 1, 3'b001);
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 1, 2, 4'h1, 2, 1, 3'b001);
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 1, 3, 4'h1, 3, 1, 3'b001);
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 1, 3, 4'h1, 4, 1, 3'b001);
        add(0, 1, 0, 1, 0,  1, 0, 0, 0, 1, 3, 4'h1, 5, 1, 3'b001);
        add(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 3, 4'h3, 5, 1, 3'b001);
        add(0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 3, 4'h7, 6, 1, 3'b001);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 3, 4'hF, 7, 1, 3'b001);
        // timeout: only 000 for 16 RUN clocks
        add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
        for (int i = 0; i < 16; i++)
            add(0, 1, 0, 0, 0, (i < 15), (i == 15), 0, (i == 15), 0, 0,
                (i == 0) ? 4'h0 : 4'h1, 0, 0, 3'd0);

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].st, rows[i].v, rows[i].a, rows[i].b, rows[i].c);
            tick();
            chk($sformatf("row%0d busy", i), busy, rows[i].busy);
            chk($sformatf("row%0d done", i), done, rows[i].done);
            chk($sformatf("row%0d pass", i), pass, rows[i].pass);
            chk($sformatf("row%0d timeout", i), timeout, rows[i].to);
            chk($sformatf("row%0d err_pulse", i), err_pulse, rows[i].ep);
            chk($sformatf("row%0d err_cnt", i), err_cnt, rows[i].cnt);
            chk($sformatf("row%0d cov", i), cov, rows[i].cov);
            chk($sformatf("row%0d b_err_cnt", i), b_err_cnt, rows[i].cntb);
`ifdef GATE_CHK_FIRST_ERR_EN
            chk($sformatf("row%0d first_err_vld", i), fev, rows[i].fv);
            chk($sformatf("row%0d first_err_vec", i), fvec, rows[i].fvec);
`endif
        end

        // Reset mid-run after two accepted (mismatching) samples.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 1); tick();
        drive(0, 1, 0, 1, 1); tick();
        chk("midrun err_cnt", err_cnt, 2'd1);
        chk("midrun cov", cov, 4'h1);
        rst = 1'b1;
        drive(0, 1, 1, 1, 1); tick();
        chk_reset_state("midrun rst");
        rst = 1'b0;
        drive(0, 1, 0, 1, 1); tick();
        drive(0, 1, 1, 0, 1); tick();
        drive(0, 1, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk_reset_state("post rst smp");

        // Coverage completes exactly on the limit edge: coverage wins.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) tick();
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 1, 0, 1, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        drive(0, 1, 1, 1, 1); tick();
        chk("edge busy", busy, 1'b1);
        chk("edge cov", cov, 4'h7);
        drive(0, 0, 0, 0, 0); tick();
        chk("edge done", done, 1'b1);
        chk("edge timeout", timeout, 1'b0);
        chk("edge pass", pass, 1'b1);
        chk("edge cov full", cov, 4'hF);
        chk("edge b_err_cnt", b_err_cnt, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for two-input gate DUTs: the receiving end of the gate stimulus flow. It samples each applied `{a,b}` vector together with the DUT output `c` and compares `c` against a parameterized truth table. It tracks coverage of all four input combinations, counts mismatches, and reports a pass/fail verdict. It sits beside any basic-gate DUT on-chip or in a bench, so a gate block can be checked without a `$monitor` printout.

## Interface
- `TRUTH_TABLE`, default `4'b1000`: expected `c` indexed by `{a,b}`; bit 3 is for a=1,b=1. The default is AND.
- `ERR_W`, default `8`: width of the saturating mismatch counter.
- `TIMEOUT`, default `64`: maximum number of clocks allowed in RUN before all four vectors are covered; must be ≥ 2.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a check run. Sampled in IDLE and DONE; ignored in RUN.
- `smp_vld` in 1: `a`/`b`/`c` are valid this cycle. Accepted only in RUN.
- `a`, `b` in 1: input vector that was applied to the DUT.
- `c` in 1: DUT output observed for that vector.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE; held until the next `start` or `rst`.
- `pass` out 1: valid while `done`; equals (`err_cnt`==0) and not `timeout`.
- `timeout` out 1: the run ended because the TIMEOUT limit was reached.
- `err_pulse` out 1: one-clock pulse per mismatch.
- `err_cnt` out ERR_W: mismatch count; saturates at 2^ERR_W−1.
- `cov` out 4: bit `{a,b}` is set once that vector has been checked.
- `first_err_vld` out 1, `first_err_vec` out 3: the `{a,b,c}` of the first mismatch. Present only with `GATE_CHK_FIRST_ERR_EN`.

## Operation
- States: IDLE → RUN on `start`; RUN → DONE on full coverage or timeout; DONE → RUN on `start`. `rst` forces IDLE from any state.
- Entering RUN from `start` clears `err_cnt`, `cov`, `timeout`, `pass`, the first-error capture, the cycle counter and the sample stage.
- Stage 1: when in RUN with `smp_vld`=1, `{a,b,c}` is registered into the sample stage.
- Stage 2: the next clock compares `c` with `TRUTH_TABLE[{a,b}]` and sets `cov[{a,b}]`.
  - On a mismatch, `err_pulse`=1 for one clock and `err_cnt` increments, saturating.
- Repeated vectors are all checked and all counted; `cov` bits never clear during a run.
- The cycle counter increments on each clock in RUN. When it reaches TIMEOUT−1 and `cov` will not become 4'hF on that edge, the block goes to DONE with `timeout`=1.
- If full coverage and timeout occur on the same edge, coverage wins: `timeout`=0 and `pass` is evaluated normally.
- On entering DONE, any sample still in stage 1 is discarded: it is not compared and not counted.
- `smp_vld` in IDLE or DONE is ignored and leaves no state change.
- Reset values: `busy`, `done`, `pass`, `timeout`, `err_pulse`, `first_err_vld` = 0; `err_cnt`=0; `cov`=4'h0; `first_err_vec`=3'b000.

## Timing
- Sample to result: `smp_vld` sampled at edge k. `err_pulse`, `err_cnt`, `cov` and `first_err_*` are updated at edge k+1.
- Last covering sample at edge k: `done`/`pass` are high and `busy` is low after edge k+1.
- Throughput: one sample per clock, with back-to-back `smp_vld` supported.
- `start` at edge k in IDLE or DONE: `busy`=1 and all statistics are cleared after edge k. A `smp_vld` on that same edge is ignored.
- `rst` mid-run: after that edge all outputs hold their reset values; the in-flight sample is dropped.

## Configuration
- `GATE_CHK_FIRST_ERR_EN` defined:
  - `first_err_vld`/`first_err_vec` ports exist.
  - The first mismatch of a run latches its `{a,b,c}` and sets `first_err_vld`; later mismatches do not overwrite it.
  - Both are cleared by `start` and `rst`.
- Not defined: those ports and their capture registers are absent. All other behaviour is identical.

## Test plan
- Default AND table: `start`, then back-to-back 000, 010, 100, 111 → no `err_pulse`; `cov`=4'hF; `done`=1 and `pass`=1 one clock after the last sample; `err_cnt`=0.
- Injected fault: the same run with 110 as the last sample → one `err_pulse`, `err_cnt`=1, `pass`=0, `first_err_vld`=1, `first_err_vec`=3'b110.
- Timeout with TIMEOUT=16: `start`, then only vector 000 repeatedly → `done`=1, `timeout`=1, `pass`=0 after 16 RUN clocks; `cov`=4'b0001.
- Saturation with ERR_W=2, TABLE 4'b1000: five samples of 001, then the remaining vectors correct → `err_cnt`=3, five `err_pulse` pulses, `pass`=0.
- Reset mid-run: `rst` after two accepted samples → all outputs at reset values next clock; further `smp_vld` has no effect until `start`.
- Restart from DONE after the failing run: `start` → `err_cnt`=0, `cov`=0, `first_err_vld`=0, `busy`=1; a clean run then gives `pass`=1.
